// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
// Bundle between the VGA timing generator, the pixel generator and the pins.
//   pixel_in     12  {R,G,B} from the pixel generator (into the timing gen)
//   h_cnt        10  horizontal counter to the pixel generator
//   v_cnt        10  vertical counter to the pixel generator
//   pix_tick      1  1-clk pulse at the end of each pixel period
//   frame_start   1  1-clk pulse when the counters wrap to (0,0)
//   hsync/vsync   1  sync pins, aligned with RGB
//   vga_r/g/b     4  colour pins, 0 during blanking
// master = timing generator side, slave = pixel generator / observer side.
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
   logic [11:0] pixel_in;
   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic        pix_tick;
   logic        frame_start;
   logic        hsync;
   logic        vsync;
   logic [3:0]  vga_r;
   logic [3:0]  vga_g;
   logic [3:0]  vga_b;

   modport master (
      input  pixel_in,
      output h_cnt, v_cnt, pix_tick, frame_start,
      output hsync, vsync, vga_r, vga_g, vga_b
   );

   modport slave (
      output pixel_in,
      input  h_cnt, v_cnt, pix_tick, frame_start,
      input  hsync, vsync, vga_r, vga_g, vga_b
   );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Generates 640x480@60Hz VGA timing from the system clock. The counters go
// out to the pixel generator; its pixel comes back PIPE_DLY pixel ticks later,
// so blanking and sync are delayed by the same amount before RGB and sync are
// registered together onto the pins (pins lag counters by PIPE_DLY+1 ticks).
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   vga   master modport of vga_timing_gen_if (pixel_in in; counters,
//         pix_tick, frame_start, hsync, vsync, vga_r/g/b out)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int CLK_DIV   = 4,
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int PIPE_DLY  = 1,
   parameter bit SYNC_POL  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   vga_timing_gen_if.master vga
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [2:0] DIV_LAST  = 3'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS_END = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS_END = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START  = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_END    = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START  = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_END    = 10'(V_VISIBLE + V_FP + V_SYNC);

   logic [2:0]  div_cnt_r;
   logic [2:0]  div_nxt_s;
   logic        pix_tick_r;
   logic [9:0]  h_cnt_r;
   logic [9:0]  v_cnt_r;
   logic        frame_start_r;

   logic        valid_raw_s;
   logic        hs_lvl_raw_s;
   logic        vs_lvl_raw_s;
   logic        valid_dly_s;
   logic        hs_lvl_dly_s;
   logic        vs_lvl_dly_s;

   logic [11:0] rgb_r;
   logic        hsync_r;
   logic        vsync_r;

   // Divider next value: wraps at CLK_DIV-1
   always_comb begin
      div_nxt_s = 3'd0;
      if (div_cnt_r == DIV_LAST) begin
         div_nxt_s = 3'd0;
      end else begin
         div_nxt_s = div_cnt_r + 3'd1;
      end
   end

   // Clock divider; pix_tick is registered from the next divider value so it
   // is high exactly while div_cnt sits at CLK_DIV-1 (every clk when CLK_DIV=1)
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_r  <= 3'd0;
         pix_tick_r <= 1'b0;
      end else begin
         div_cnt_r  <= div_nxt_s;
         pix_tick_r <= (div_nxt_s == DIV_LAST);
      end
   end

   // Pixel/line counters and the frame wrap pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt_r       <= 10'd0;
         v_cnt_r       <= 10'd0;
         frame_start_r <= 1'b0;
      end else begin
         frame_start_r <= pix_tick_r && (h_cnt_r == H_LAST) && (v_cnt_r == V_LAST);
         if (pix_tick_r) begin
            if (h_cnt_r == H_LAST) begin
               h_cnt_r <= 10'd0;
               if (v_cnt_r == V_LAST) begin
                  v_cnt_r <= 10'd0;
               end else begin
                  v_cnt_r <= v_cnt_r + 10'd1;
               end
            end else begin
               h_cnt_r <= h_cnt_r + 10'd1;
            end
         end
      end
   end

   // Raw decode of the current counters into visibility and sync pin levels
   always_comb begin
      valid_raw_s  = (h_cnt_r < H_VIS_END) && (v_cnt_r < V_VIS_END);
      hs_lvl_raw_s = ~SYNC_POL;
      vs_lvl_raw_s = ~SYNC_POL;
      if ((h_cnt_r >= HS_START) && (h_cnt_r < HS_END)) begin
         hs_lvl_raw_s = SYNC_POL;
      end else begin
         hs_lvl_raw_s = ~SYNC_POL;
      end
      if ((v_cnt_r >= VS_START) && (v_cnt_r < VS_END)) begin
         vs_lvl_raw_s = SYNC_POL;
      end else begin
         vs_lvl_raw_s = ~SYNC_POL;
      end
   end

   // Delay line matching the pixel generator latency (pass-through when 0)
   generate
      if (PIPE_DLY == 0) begin : g_no_dly
         assign valid_dly_s  = valid_raw_s;
         assign hs_lvl_dly_s = hs_lvl_raw_s;
         assign vs_lvl_dly_s = vs_lvl_raw_s;
      end else begin : g_dly
         logic [PIPE_DLY-1:0] valid_sr_r;
         logic [PIPE_DLY-1:0] hs_sr_r;
         logic [PIPE_DLY-1:0] vs_sr_r;

         // Shift register advancing once per pixel; stage 0 takes the raw decode
         always_ff @(posedge clk) begin
            if (rst) begin
               valid_sr_r <= '0;
               hs_sr_r    <= {PIPE_DLY{~SYNC_POL}};
               vs_sr_r    <= {PIPE_DLY{~SYNC_POL}};
            end else if (pix_tick_r) begin
               valid_sr_r[0] <= valid_raw_s;
               hs_sr_r[0]    <= hs_lvl_raw_s;
               vs_sr_r[0]    <= vs_lvl_raw_s;
               for (int i = 1; i < PIPE_DLY; i++) begin
                  valid_sr_r[i] <= valid_sr_r[i-1];
                  hs_sr_r[i]    <= hs_sr_r[i-1];
                  vs_sr_r[i]    <= vs_sr_r[i-1];
               end
            end
         end

         assign valid_dly_s  = valid_sr_r[PIPE_DLY-1];
         assign hs_lvl_dly_s = hs_sr_r[PIPE_DLY-1];
         assign vs_lvl_dly_s = vs_sr_r[PIPE_DLY-1];
      end
   endgenerate

   // Pin register: RGB and both syncs change on the same clk
   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_r   <= 12'h000;
         hsync_r <= ~SYNC_POL;
         vsync_r <= ~SYNC_POL;
      end else if (pix_tick_r) begin
         rgb_r   <= valid_dly_s ? vga.pixel_in : 12'h000;
         hsync_r <= hs_lvl_dly_s;
         vsync_r <= vs_lvl_dly_s;
      end
   end

   assign vga.h_cnt       = h_cnt_r;
   assign vga.v_cnt       = v_cnt_r;
   assign vga.pix_tick    = pix_tick_r;
   assign vga.frame_start = frame_start_r;
   assign vga.hsync       = hsync_r;
   assign vga.vsync       = vsync_r;
   assign vga.vga_r       = rgb_r[11:8];
   assign vga.vga_g       = rgb_r[7:4];
   assign vga.vga_b       = rgb_r[3:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Directed bench. Instance A: default timing, CLK_DIV=4, PIPE_DLY=1.
// Instance B: CLK_DIV=1, PIPE_DLY=0, default horizontal timing and a short
// 8-line frame (4 visible, FP 1, sync 2, BP 1) so frame wrap and vsync are
// reachable quickly. Outputs are sampled on the falling edge; edge_cnt counts
// rising edges since the active instance left reset.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;

   always #5 clk = ~clk;

   vga_timing_gen_if vif_a ();
   vga_timing_gen_if vif_b ();

   vga_timing_gen #(.CLK_DIV(4), .PIPE_DLY(1)) dut_a (
      .clk (clk),
      .rst (rst_a),
      .vga (vif_a)
   );

   vga_timing_gen #(.CLK_DIV(1), .PIPE_DLY(0),
                    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_b (
      .clk (clk),
      .rst (rst_b),
      .vga (vif_b)
   );

   int n_check  = 0;
   int n_error  = 0;
   int edge_cnt = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_check++;
      if (got !== exp) begin
         n_error++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_cnt(input string tag, input logic [9:0] g_h, input logic [9:0] g_v,
                          input int e_h, input int e_v);
      check_val({tag, "_h"}, 32'(g_h), 32'(e_h));
      check_val({tag, "_v"}, 32'(g_v), 32'(e_v));
   endtask

   task automatic chk_pins(input string tag, input logic [3:0] r, input logic [3:0] g,
                           input logic [3:0] b, input logic hs, input logic vs,
                           input logic [11:0] e_rgb, input logic e_hs, input logic e_vs);
      check_val({tag, "_rgb"}, 32'({r, g, b}), 32'(e_rgb));
      check_val({tag, "_hs"},  32'(hs), 32'(e_hs));
      check_val({tag, "_vs"},  32'(vs), 32'(e_vs));
   endtask

   // advance until edge_cnt rising edges have elapsed, then settle to the falling edge
   task automatic run_to(input int target);
      while (edge_cnt < target) begin
         @(posedge clk);
         edge_cnt++;
      end
      @(negedge clk);
   endtask

   task automatic chk_a_reset(input string tag);
      chk_cnt(tag, vif_a.h_cnt, vif_a.v_cnt, 0, 0);
      check_val({tag, "_tick"}, 32'(vif_a.pix_tick), 32'd0);
      check_val({tag, "_fs"},   32'(vif_a.frame_start), 32'd0);
      chk_pins(tag, vif_a.vga_r, vif_a.vga_g, vif_a.vga_b, vif_a.hsync, vif_a.vsync,
               12'h000, 1'b1, 1'b1);
   endtask

   `define PINS_A(tag, rgb, hs, vs) chk_pins(tag, vif_a.vga_r, vif_a.vga_g, vif_a.vga_b, vif_a.hsync, vif_a.vsync, rgb, hs, vs)
   `define PINS_B(tag, rgb, hs, vs) chk_pins(tag, vif_b.vga_r, vif_b.vga_g, vif_b.vga_b, vif_b.hsync, vif_b.vsync, rgb, hs, vs)

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      vif_a.pixel_in = 12'hA5C;
      vif_b.pixel_in = 12'hFFF;
      repeat (3) @(negedge clk);

      // reset state of both instances
      chk_a_reset("rst_a");
      chk_cnt("rst_b", vif_b.h_cnt, vif_b.v_cnt, 0, 0);
      check_val("rst_b_tick", 32'(vif_b.pix_tick), 32'd0);
      `PINS_B("rst_b", 12'h000, 1'b1, 1'b1);

      // ---------------- instance A: CLK_DIV=4, PIPE_DLY=1 ----------------
      rst_a = 1'b0;
      edge_cnt = 0;
      run_to(3);
      check_val("a_tick3", 32'(vif_a.pix_tick), 32'd1);
      chk_cnt("a_e3", vif_a.h_cnt, vif_a.v_cnt, 0, 0);
      run_to(4);
      check_val("a_tick4", 32'(vif_a.pix_tick), 32'd0);
      chk_cnt("a_e4", vif_a.h_cnt, vif_a.v_cnt, 1, 0);
      `PINS_A("a_e4", 12'h000, 1'b1, 1'b1);
      run_to(7);
      check_val("a_tick7", 32'(vif_a.pix_tick), 32'd1);
      `PINS_A("a_e7", 12'h000, 1'b1, 1'b1);
      run_to(8);
      chk_cnt("a_e8", vif_a.h_cnt, vif_a.v_cnt, 2, 0);
      `PINS_A("a_first_px", 12'hA5C, 1'b1, 1'b1);
      run_to(2564);
      `PINS_A("a_px639", 12'hA5C, 1'b1, 1'b1);
      run_to(2568);
      `PINS_A("a_px640", 12'h000, 1'b1, 1'b1);
      run_to(2628);
      `PINS_A("a_px655", 12'h000, 1'b1, 1'b1);
      run_to(2632);
      `PINS_A("a_px656", 12'h000, 1'b0, 1'b1);
      run_to(3012);
      `PINS_A("a_px751", 12'h000, 1'b0, 1'b1);
      run_to(3016);
      `PINS_A("a_px752", 12'h000, 1'b1, 1'b1);
      run_to(3199);
      chk_cnt("a_h799", vif_a.h_cnt, vif_a.v_cnt, 799, 0);
      run_to(3200);
      chk_cnt("a_wrap", vif_a.h_cnt, vif_a.v_cnt, 0, 1);
      check_val("a_wrap_fs", 32'(vif_a.frame_start), 32'd0);
      `PINS_A("a_px798", 12'h000, 1'b1, 1'b1);
      run_to(3204);
      `PINS_A("a_px799", 12'h000, 1'b1, 1'b1);
      run_to(3208);
      `PINS_A("a_line1_px0", 12'hA5C, 1'b1, 1'b1);
      run_to(4400);
      chk_cnt("a_mid", vif_a.h_cnt, vif_a.v_cnt, 300, 1);
      `PINS_A("a_mid", 12'hA5C, 1'b1, 1'b1);

      // mid-line reset aborts immediately and counting restarts from (0,0)
      rst_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_a_reset("a_midrst");
      rst_a = 1'b0;
      edge_cnt = 0;
      run_to(3);
      check_val("a_re_tick3", 32'(vif_a.pix_tick), 32'd1);
      chk_cnt("a_re_e3", vif_a.h_cnt, vif_a.v_cnt, 0, 0);
      run_to(4);
      chk_cnt("a_re_e4", vif_a.h_cnt, vif_a.v_cnt, 1, 0);

      // ---------------- instance B: CLK_DIV=1, PIPE_DLY=0 ----------------
      rst_b = 1'b0;
      edge_cnt = 0;
      run_to(1);
      check_val("b_tick1", 32'(vif_b.pix_tick), 32'd1);
      check_val("b_fs_init", 32'(vif_b.frame_start), 32'd0);
      chk_cnt("b_e1", vif_b.h_cnt, vif_b.v_cnt, 0, 0);
      `PINS_B("b_e1", 12'h000, 1'b1, 1'b1);
      run_to(2);
      check_val("b_tick2", 32'(vif_b.pix_tick), 32'd1);
      chk_cnt("b_e2", vif_b.h_cnt, vif_b.v_cnt, 1, 0);
      `PINS_B("b_first_px", 12'hFFF, 1'b1, 1'b1);
      run_to(641);
      `PINS_B("b_px639", 12'hFFF, 1'b1, 1'b1);
      run_to(642);
      `PINS_B("b_px640", 12'h000, 1'b1, 1'b1);
      run_to(657);
      `PINS_B("b_px655", 12'h000, 1'b1, 1'b1);
      run_to(658);
      `PINS_B("b_px656", 12'h000, 1'b0, 1'b1);
      run_to(753);
      `PINS_B("b_px751", 12'h000, 1'b0, 1'b1);
      run_to(754);
      `PINS_B("b_px752", 12'h000, 1'b1, 1'b1);
      run_to(800);
      chk_cnt("b_h799", vif_b.h_cnt, vif_b.v_cnt, 799, 0);
      run_to(801);
      chk_cnt("b_line", vif_b.h_cnt, vif_b.v_cnt, 0, 1);
      run_to(2412);
      chk_cnt("b_l3", vif_b.h_cnt, vif_b.v_cnt, 11, 3);
      `PINS_B("b_l3", 12'hFFF, 1'b1, 1'b1);
      run_to(3212);
      `PINS_B("b_l4_blank", 12'h000, 1'b1, 1'b1);
      run_to(4001);
      `PINS_B("b_l4_end", 12'h000, 1'b1, 1'b1);
      run_to(4002);
      `PINS_B("b_vs_on", 12'h000, 1'b1, 1'b0);
      run_to(5601);
      `PINS_B("b_vs_last", 12'h000, 1'b1, 1'b0);
      run_to(5602);
      `PINS_B("b_vs_off", 12'h000, 1'b1, 1'b1);
      run_to(6400);
      chk_cnt("b_last", vif_b.h_cnt, vif_b.v_cnt, 799, 7);
      check_val("b_fs_pre", 32'(vif_b.frame_start), 32'd0);
      run_to(6401);
      chk_cnt("b_fwrap", vif_b.h_cnt, vif_b.v_cnt, 0, 0);
      check_val("b_fs", 32'(vif_b.frame_start), 32'd1);
      run_to(6402);
      check_val("b_fs_post", 32'(vif_b.frame_start), 32'd0);
      `PINS_B("b_f2_px0", 12'hFFF, 1'b1, 1'b1);
      run_to(12800);
      check_val("b_fs2_pre", 32'(vif_b.frame_start), 32'd0);
      run_to(12801);
      check_val("b_fs2", 32'(vif_b.frame_start), 32'd1);
      chk_cnt("b_fwrap2", vif_b.h_cnt, vif_b.v_cnt, 0, 0);

      $display("CHECKS %0d ERRORS %0d", n_check, n_error);
      $finish;
   end

endmodule
